// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared sequencer state, trap cause and write-source encodings
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    TRAP_NONE     = 2'd0,
    TRAP_ILLEGAL  = 2'd1,
    TRAP_MISALIGN = 2'd2,
    TRAP_TIMEOUT  = 2'd3
  } trap_cause_e;

  // Write-back source select shared with the instruction control decoder.
  typedef enum logic [1:0] {
    WSRC_ALU = 2'd0,
    WSRC_REG = 2'd1,
    WSRC_XMM = 2'd2,
    WSRC_MEM = 2'd3
  } wb_src_e;

  localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0013;

  function automatic logic [31:0] next_pc(input logic [31:0] cur_pc,
                                          input logic        take,
                                          input logic [31:0] target);
    return take ? target : cur_pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction and data memory handshake bundle
interface instr_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - 8-bit bus wait counter with clear, enable and timeout flag
module bus_wait_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  // Fires on the cycle whose increment would bring the count to LIMIT.
  assign timeout = en && (count_q == (LIMIT - 8'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/mem/write-back controller
module instr_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd255,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_WORD
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  instr_sequencer_if.master  bus,
  output logic [31:0]        ir,
  input  logic               dec_read_mem,
  input  logic               dec_write_mem,
  input  logic               dec_write_reg,
  input  logic               dec_write_xmm,
  input  logic               illegal_instr,
  input  logic               take_branch,
  input  logic [31:0]        branch_target,
  output logic               reg_we,
  output logic               xmm_we,
  output logic [31:0]        pc,
  output logic [31:0]        instret,
  output logic               halted,
  output logic [1:0]         trap_cause
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q, instret_d;
  logic        halted_q, halted_d;
  trap_cause_e cause_q, cause_d;

  logic imem_req_s;
  logic dmem_req_s;
  logic timer_en;
  logic timer_clr;
  logic bus_timeout;
  logic wb_misalign;

  // Every state leading into FETCH or MEM holds the counter at zero.
  assign timer_clr = !((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign timer_en  = ((state_q == ST_FETCH) && !bus.imem_ack) ||
                     ((state_q == ST_MEM)   && !bus.dmem_ack);

  bus_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .timeout (bus_timeout)
  );

  assign wb_misalign = take_branch && (branch_target[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    instret_d  = instret_q;
    halted_d   = halted_q;
    cause_d    = cause_q;
    imem_req_s = 1'b0;
    dmem_req_s = 1'b0;
    reg_we     = 1'b0;
    xmm_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = ST_DECODE;
        end else if (bus_timeout) begin
          state_d  = ST_TRAP;
          halted_d = 1'b1;
          cause_d  = TRAP_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (illegal_instr || (dec_read_mem && dec_write_mem)) begin
          state_d  = ST_TRAP;
          halted_d = 1'b1;
          cause_d  = TRAP_ILLEGAL;
        end else if (dec_read_mem || dec_write_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req_s = 1'b1;
        if (bus.dmem_ack) begin
          state_d = ST_WB;
        end else if (bus_timeout) begin
          state_d  = ST_TRAP;
          halted_d = 1'b1;
          cause_d  = TRAP_TIMEOUT;
        end
      end
      ST_WB: begin
        if (wb_misalign) begin
          state_d  = ST_TRAP;
          halted_d = 1'b1;
          cause_d  = TRAP_MISALIGN;
        end else begin
          reg_we    = dec_write_reg;
          xmm_we    = dec_write_xmm;
          pc_d      = next_pc(pc_q, take_branch, branch_target);
          instret_d = instret_q + 32'd1;
          state_d   = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSTR;
      instret_q <= 32'd0;
      halted_q  <= 1'b0;
      cause_q   <= TRAP_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
      cause_q   <= cause_d;
    end
  end

  assign bus.imem_req  = imem_req_s;
  assign bus.imem_addr = pc_q;
  assign bus.dmem_req  = dmem_req_s;
  assign bus.dmem_we   = dmem_req_s && dec_write_mem;

  assign ir         = ir_q;
  assign pc         = pc_q;
  assign instret    = instret_q;
  assign halted     = halted_q;
  assign trap_cause = cause_q;

endmodule
